// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants, FSM encoding and pixel field layout
package vga_pkg;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    function automatic logic [9:0] cnt_last(input int a, input int f, input int s, input int b);
        return 10'(a + f + s + b - 1);
    endfunction
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running h/v counters with sync and active-region decode
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_en,
    output logic [9:0] hcnt,
    output logic [9:0] vcnt,
    output logic       active,
    output logic       hs_n,
    output logic       vs_n
);
    localparam logic [9:0] H_LAST = cnt_last(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam logic [9:0] V_LAST = cnt_last(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [9:0] HA  = 10'(H_ACTIVE);
    localparam logic [9:0] VA  = 10'(V_ACTIVE);
    localparam logic [9:0] HS0 = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS1 = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS0 = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS1 = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // raster counters: held at the origin whenever scan-out is not running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (!run_en) begin
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            hcnt <= (hcnt == H_LAST) ? '0 : hcnt + 10'd1;
            if (hcnt == H_LAST)
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
        end
    end

    // position decode for the current count
    always_comb begin
        active = (hcnt < HA) && (vcnt < VA);
        hs_n   = !((hcnt >= HS0) && (hcnt <= HS1));
        vs_n   = !((vcnt >= VS0) && (vcnt <= VS1));
    end
endmodule

// File: rtl/vga_scan_out.sv
// vga_scan_out: scan-out FSM pulling pixels from a show-ahead FIFO onto registered VGA outputs
module vga_scan_out
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        clr_underflow,
    input  logic        fifo_empty,
    input  logic [23:0] fifo_data,
    output logic        fifo_rd,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        frame_start,
    output logic        underflow
);
    localparam logic [9:0] H_LAST = cnt_last(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam logic [9:0] V_LAST = cnt_last(V_ACTIVE, V_FP, V_SYNC, V_BP);

    state_t     state;
    logic [9:0] hcnt, vcnt;
    logic       active, hs_n, vs_n;
    logic       show, starved;
    pixel_t     px;

    assign px = pixel_t'(fifo_data);

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk   (clk),
        .rst   (rst),
        .run_en(enable && state != IDLE),
        .hcnt  (hcnt),
        .vcnt  (vcnt),
        .active(active),
        .hs_n  (hs_n),
        .vs_n  (vs_n)
    );

    // pixel demand this cycle; a stop request suppresses the pop so no word is lost
    always_comb begin
        show    = enable && state == RUN && active;
        fifo_rd = show && !fifo_empty;
        starved = show && fifo_empty;
    end

    // FSM and registered video outputs, all delayed one cycle from the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank       <= 1'b1;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            underflow <= starved || (underflow && !clr_underflow);
            if (!enable || state == IDLE) begin
                state       <= enable ? SYNC : IDLE;
                hsync       <= 1'b1;
                vsync       <= 1'b1;
                blank       <= 1'b1;
                red         <= '0;
                green       <= '0;
                blue        <= '0;
                frame_start <= 1'b0;
            end else begin
                hsync       <= hs_n;
                vsync       <= vs_n;
                blank       <= !active;
                red         <= fifo_rd ? px.r : '0;
                green       <= fifo_rd ? px.g : '0;
                blue        <= fifo_rd ? px.b : '0;
                frame_start <= state == RUN && hcnt == '0 && vcnt == '0;
                if (state == SYNC && hcnt == H_LAST && vcnt == V_LAST && !fifo_empty)
                    state <= RUN;
            end
        end
    end
endmodule

// File: tb/tb_vga_scan_out.sv
// tb_vga_scan_out: table vectors, directed corner sequences and random traffic against a frame-position model
module tb_vga_scan_out;
    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 6, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;

    logic        clk = 1'b0, rst, enable, clr_underflow, fifo_empty;
    logic [23:0] fifo_data;
    logic        fifo_rd, hsync, vsync, blank, frame_start, underflow;
    logic [7:0]  red, green, blue;

    vga_scan_out #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .clr_underflow(clr_underflow),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd(fifo_rd),
        .hsync(hsync), .vsync(vsync), .blank(blank), .red(red), .green(green),
        .blue(blue), .frame_start(frame_start), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int ms, pos;
    logic e_hs, e_vs, e_bl, e_fs, e_uf;
    logic [23:0] e_rgb;
    logic [23:0] q[$];
    logic [23:0] nextw;
    bit starve, refill, rnd_fill;
    int c_hs, c_vs, c_rd, c_fs;

    typedef struct {
        logic en, emp;
        logic [23:0] data;
        logic e_rd, e_hs, e_vs, e_bl, e_fs;
        logic [23:0] e_rgb;
    } vec_t;
    vec_t tbl[4];

    function automatic void chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, a, e);
    endfunction

    function automatic void model_reset();
        ms = 0; pos = 0;
        e_hs = 1; e_vs = 1; e_bl = 1; e_fs = 0; e_uf = 0; e_rgb = 0;
    endfunction

    function automatic void chk_outs(input string tag);
        chk({tag, "_hsync"}, hsync, e_hs);
        chk({tag, "_vsync"}, vsync, e_vs);
        chk({tag, "_blank"}, blank, e_bl);
        chk({tag, "_rgb"}, {red, green, blue}, e_rgb);
        chk({tag, "_frame_start"}, frame_start, e_fs);
        chk({tag, "_underflow"}, underflow, e_uf);
    endfunction

    // one pixel clock: entered and left at a falling edge
    task automatic cyc();
        int h, v;
        bit act, live, rd_seen;
        fifo_empty = starve || q.size() == 0;
        fifo_data  = (q.size() != 0) ? q[0] : 24'($urandom);
        #1;
        h = pos % HT;
        v = (pos / HT) % VT;
        act  = ms != 0 && h < HA && v < VA;
        live = enable && ms == 2 && act;
        rd_seen = fifo_rd;
        chk("fifo_rd", fifo_rd, live && !fifo_empty);
        @(posedge clk);
        if (rd_seen && q.size() != 0) void'(q.pop_front());
        c_rd += int'(rd_seen);
        e_uf = (live && fifo_empty) || (e_uf && !clr_underflow);
        if (!enable || ms == 0) begin
            e_hs = 1; e_vs = 1; e_bl = 1; e_rgb = 0; e_fs = 0;
            ms = enable ? 1 : 0;
            pos = 0;
        end else begin
            e_hs  = !(h >= HA + HF && h < HA + HF + HS);
            e_vs  = !(v >= VA + VF && v < VA + VF + VS);
            e_bl  = !act;
            e_rgb = (live && !fifo_empty) ? fifo_data : 24'h0;
            e_fs  = ms == 2 && pos % FR == 0;
            if (ms == 1 && pos % FR == FR - 1 && !fifo_empty) ms = 2;
            pos++;
        end
        @(negedge clk);
        chk_outs("cyc");
        c_hs += int'(!hsync);
        c_vs += int'(!vsync);
        c_fs += int'(frame_start);
        if (refill)
            while (q.size() < 16) begin
                q.push_back(rnd_fill ? 24'($urandom) : nextw);
                nextw++;
            end
    endtask

    task automatic zero_counts();
        c_hs = 0; c_vs = 0; c_rd = 0; c_fs = 0;
    endtask

    task automatic wait_pos(input int p);
        int k = 0;
        while (!(ms == 2 && pos % FR == p) && k < 2 * FR) begin cyc(); k++; end
        chk("wait_pos_reached", k < 2 * FR, 1);
    endtask

    task automatic wait_fs(input string nm);
        int k = 0;
        while (frame_start !== 1'b1 && k < 2 * FR + 5) begin cyc(); k++; end
        chk(nm, frame_start, 1);
    endtask

    task automatic preload();
        q.delete();
        nextw = 24'h1;
        for (int i = 0; i < 16; i++) begin q.push_back(nextw); nextw++; end
    endtask

    initial begin
        rst = 1; enable = 0; clr_underflow = 0; fifo_empty = 1; fifo_data = 0;
        starve = 0; refill = 0; rnd_fill = 0;
        model_reset();
        zero_counts();
        tbl[0] = '{1'b0, 1'b1, 24'h0,      1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h0};
        tbl[1] = '{1'b0, 1'b0, 24'habcdef, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h0};
        tbl[2] = '{1'b1, 1'b0, 24'h123456, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h0};
        tbl[3] = '{1'b1, 1'b0, 24'h654321, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0};

        @(negedge clk);
        chk_outs("reset");
        chk("reset_fifo_rd", fifo_rd, 0);
        rst = 0;

        foreach (tbl[i]) begin
            enable = tbl[i].en; fifo_empty = tbl[i].emp; fifo_data = tbl[i].data;
            #1;
            chk($sformatf("tbl%0d_fifo_rd", i), fifo_rd, tbl[i].e_rd);
            @(negedge clk);
            chk($sformatf("tbl%0d_hsync", i), hsync, tbl[i].e_hs);
            chk($sformatf("tbl%0d_vsync", i), vsync, tbl[i].e_vs);
            chk($sformatf("tbl%0d_blank", i), blank, tbl[i].e_bl);
            chk($sformatf("tbl%0d_rgb", i), {red, green, blue}, tbl[i].e_rgb);
            chk($sformatf("tbl%0d_frame_start", i), frame_start, tbl[i].e_fs);
        end

        rst = 1;
        #1;
        chk("async_rst_blank", blank, 1);
        @(negedge clk);
        rst = 0; enable = 1; starve = 1;
        model_reset();

        repeat (12) cyc();
        zero_counts();
        repeat (FR) cyc();
        chk("sync_hs_low_per_frame", c_hs, HS * VT);
        chk("sync_vs_low_per_frame", c_vs, VS * HT);
        chk("sync_no_reads", c_rd, 0);
        repeat (FR) cyc();
        chk("sync_still_no_reads", c_rd, 0);

        starve = 0; refill = 1;
        preload();
        wait_fs("run_first_frame_start");
        chk("run_first_pixel", {red, green, blue}, 24'h000001);
        zero_counts();
        repeat (FR) cyc();
        chk("run_reads_per_frame", c_rd, HA * VA);
        chk("run_frame_starts_per_frame", c_fs, 1);

        wait_pos(2 * HT + 5);
        starve = 1;
        repeat (3) cyc();
        starve = 0;
        cyc();
        chk("underflow_set", underflow, 1);
        clr_underflow = 1;
        cyc();
        clr_underflow = 0;
        chk("underflow_cleared", underflow, 0);

        wait_pos(3 * HT + 1);
        starve = 1; clr_underflow = 1;
        cyc();
        starve = 0; clr_underflow = 0;
        chk("underflow_set_beats_clear", underflow, 1);
        clr_underflow = 1;
        cyc();
        clr_underflow = 0;

        wait_pos(4 * HT + 3);
        enable = 0;
        cyc();
        chk("stop_blank", blank, 1);
        chk("stop_hsync", hsync, 1);
        enable = 1;
        zero_counts();
        repeat (FR) cyc();
        chk("restart_no_reads_before_boundary", c_rd, 0);
        wait_fs("restart_frame_start");

        wait_pos(HT + 2);
        rst = 1;
        #1;
        chk("midline_rst_blank", blank, 1);
        chk("midline_rst_rgb", {red, green, blue}, 0);
        chk("midline_rst_fifo_rd", fifo_rd, 0);
        @(negedge clk);
        rst = 0;
        model_reset();
        preload();
        chk_outs("after_rst");
        zero_counts();
        repeat (FR) cyc();
        chk("after_rst_no_reads", c_rd, 0);
        wait_fs("after_rst_frame_start");

        rnd_fill = 1;
        for (int i = 0; i < 600; i++) begin
            starve        = $urandom_range(7) == 0;
            clr_underflow = $urandom_range(15) == 0;
            enable        = $urandom_range(199) != 0;
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/vga_scan_out.md
VGA_SCAN_OUT -- requirements
Module: vga_scan_out

Interface
REQ-001 SHALL have parameters: H_ACTIVE 640 visible pixels; H_FP 16, H_SYNC 96, H_BP 48 (H total 800); V_ACTIVE 480 visible lines; V_FP 10, V_SYNC 2, V_BP 33 (V total 525).
REQ-002 SHALL have ports, one per line:
  clk  in  1  pixel clock (25.175 MHz nominal)
  rst  in  1  reset, asynchronous, active-high
  enable  in  1  start scan-out (1) / stop scan-out (0)
  clr_underflow  in  1  clears the underflow flag
  fifo_empty  in  1  pixel FIFO has no entries
  fifo_data  in  24  show-ahead head word {R[23:16],G[15:8],B[7:0]}, valid whenever !fifo_empty
  fifo_rd  out  1  pop FIFO head this cycle
  hsync  out  1  horizontal sync, active-low
  vsync  out  1  vertical sync, active-low
  blank  out  1  1 outside the active region
  red, green, blue  out  8 each  pixel colour
  frame_start  out  1  one-cycle pulse at pixel (0,0) in RUN
  underflow  out  1  sticky FIFO-starved flag

Function
REQ-003 SHALL keep hcnt (10 b, 0..799) and vcnt (10 b, 0..524); hcnt wraps 799->0 and increments vcnt; vcnt wraps 524->0 when hcnt wraps.
REQ-004 SHALL define active = (hcnt < 640) && (vcnt < 480).
REQ-005 SHALL have a 3-state FSM: IDLE, SYNC, RUN.
REQ-006 IDLE: counters held at 0; fifo_rd=0; outputs at reset values; enable=1 -> SYNC.
REQ-007 SYNC: counters run; sync outputs generated; fifo_rd=0; colour 0; at (hcnt,vcnt)=(799,524): if !fifo_empty -> RUN, else stay in SYNC.
REQ-008 RUN: fifo_rd = active && !fifo_empty (combinational, same cycle as the count).
REQ-009 enable=0 in any state SHALL force IDLE on the next edge and zero the counters; no frame is completed.
REQ-010 All of hsync, vsync, blank, red, green, blue and frame_start SHALL be registered; they appear exactly 1 cycle after the counter value that produced them, so all of them stay mutually aligned.
REQ-011 hsync low when 656 <= hcnt <= 751; vsync low when 490 <= vcnt <= 491; both apply in SYNC and RUN.
REQ-012 Colour: active && RUN && !fifo_empty -> fifo_data; any other case -> 0.
REQ-013 Underflow: active && RUN && fifo_empty SHALL output black for that pixel and set underflow.
REQ-014 After an underflow the block SHALL stay in RUN, and later pixels resume from the FIFO head; there is no skip or realign.
REQ-015 underflow SHALL clear on clr_underflow=1, except when a new underflow occurs in the same cycle: then set wins.
REQ-016 fifo_rd SHALL never assert while fifo_empty=1, and SHALL assert at most once per cycle.
REQ-017 frame_start SHALL pulse when the registered outputs show (0,0) and the FSM was in RUN at the count cycle.

Reset
REQ-018 On rst: state=IDLE, hcnt=vcnt=0, fifo_rd=0, hsync=1, vsync=1, blank=1, red=green=blue=0, frame_start=0, underflow=0.
REQ-019 rst asserted mid-frame SHALL take effect at once; the upstream FIFO is reset by the same rst.

Structure
REQ-020 H/V timing constants, the FSM state encoding and the 24-bit pixel field slicing SHALL live in the shared package vga_pkg.
REQ-021 Counters and the sync/active decode SHALL be the sub-module vga_timing_gen (ports: clk, rst, run_en, hcnt, vcnt, active, hs_n, vs_n).
REQ-022 The FSM, FIFO read and output registers SHALL live in vga_scan_out.

Verification
REQ-023 Reset, then enable=1 with fifo_empty=1 for 2 frames -> state stays SYNC; fifo_rd never asserts; hsync low period 96 clks every 800; vsync low for 1600 clks every 420000.
REQ-024 Preload FIFO model with 16 words 0x000001..0x000010, keep it refilled -> RUN after first (799,524); fifo_rd asserts 640 cycles/line x 480 lines; first visible pixel 0x000001 one cycle after (0,0); frame_start pulses once per frame.
REQ-025 In RUN, FIFO empties at hcnt=100, vcnt=5 for 3 cycles -> 3 black pixels, underflow=1, next pixel is the next FIFO word; clr_underflow -> underflow=0.
REQ-026 Assert clr_underflow in the same cycle as a new underflow -> underflow stays 1.
REQ-027 Deassert enable at hcnt=300, vcnt=200 -> next cycle IDLE, counters 0, outputs at reset values; re-enable -> SYNC first, with no reads until the frame boundary.
REQ-028 Pulse rst for 1 clk mid-active-line -> all outputs at reset values asynchronously; no fifo_rd until the SYNC->RUN transition.
